// File: rtl/lfsr_seq_checker_if.sv
// Serial-stream bundle between the shift-register observe side and lfsr_seq_checker.
// The master drives the bit stream and the error-clear request; the slave returns status.
interface lfsr_seq_checker_if #(
  parameter int WIDTH = 5,
  parameter int ERR_W = 8
);
  logic             din_valid;
  logic             din;
  logic             clr_err;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;
  logic [WIDTH-1:0] hist_out;

  modport master (
    output din_valid, din, clr_err,
    input  locked, err_pulse, err_count, hist_out
  );

  modport slave (
    input  din_valid, din, clr_err,
    output locked, err_pulse, err_count, hist_out
  );
endinterface

// File: rtl/lfsr_seq_checker.sv
// Self-synchronising 5-bit Fibonacci LFSR stream checker with lock / loss-of-lock tracking.
// Define LFSR_CHK_ERRCNT_EN to build the saturating err_count counter and its clr_err clear.
module lfsr_seq_checker #(
  parameter int               WIDTH      = 5,
  parameter logic [WIDTH-1:0] TAPS       = 5'b10100,
  parameter int               LOCK_COUNT = 8,
  parameter int               LOSS_COUNT = 4,
  parameter int               ERR_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  lfsr_seq_checker_if.slave  bus
);

  localparam int              FILL_W    = $clog2(WIDTH + 1);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(WIDTH - 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WIDTH);
  localparam logic [7:0]      LOCK_LAST = 8'(LOCK_COUNT - 1);
  localparam logic [3:0]      BAD_LAST  = 4'(LOSS_COUNT - 1);

  typedef enum logic [1:0] {ACQ, CHECK, LOCKED} state_t;

  state_t            state;
  logic [FILL_W-1:0] fill_cnt;
  logic [7:0]        match_cnt;
  logic [3:0]        bad_cnt;
  logic [WIDTH-1:0]  hist;
  logic              locked_q;
  logic              err_pulse_q;

  logic              vld_p0;
  logic              pred_p0;
  logic              mis_p0;
  logic [WIDTH-1:0]  hist_nxt_p0;

  // Stage p0: prediction from the pre-shift history, compared against the incoming bit.
  assign vld_p0      = bus.din_valid;
  assign pred_p0     = ^(hist & TAPS);
  assign mis_p0      = vld_p0 & (bus.din != pred_p0);
  assign hist_nxt_p0 = {hist[WIDTH-2:0], bus.din};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ACQ;
      fill_cnt    <= '0;
      match_cnt   <= '0;
      bad_cnt     <= '0;
      hist        <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      err_pulse_q <= 1'b0;
      if (vld_p0) begin
        hist <= hist_nxt_p0;
        case (state)
          ACQ: begin
            if (fill_cnt != FILL_FULL) fill_cnt <= fill_cnt + 1'b1;
            // An all-zero history is the LFSR lock-up state and is never checked.
            if (fill_cnt >= FILL_LAST && hist_nxt_p0 != '0) begin
              state     <= CHECK;
              match_cnt <= '0;
            end
          end
          CHECK: begin
            if (hist_nxt_p0 == '0) begin
              state    <= ACQ;
              fill_cnt <= '0;
            end else if (mis_p0) begin
              match_cnt <= '0;
            end else if (match_cnt == LOCK_LAST) begin
              state     <= LOCKED;
              locked_q  <= 1'b1;
              match_cnt <= '0;
              bad_cnt   <= '0;
            end else begin
              match_cnt <= match_cnt + 1'b1;
            end
          end
          LOCKED: begin
            if (mis_p0) begin
              err_pulse_q <= 1'b1;
              match_cnt   <= '0;
              if (bad_cnt == BAD_LAST) begin
                state    <= ACQ;
                locked_q <= 1'b0;
                fill_cnt <= '0;
                bad_cnt  <= '0;
              end else begin
                bad_cnt <= bad_cnt + 1'b1;
              end
            end else if (match_cnt == LOCK_LAST) begin
              match_cnt <= '0;
              bad_cnt   <= '0;
            end else begin
              match_cnt <= match_cnt + 1'b1;
            end
          end
          default: begin
            state    <= ACQ;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef LFSR_CHK_ERRCNT_EN
  logic [ERR_W-1:0] err_cnt;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Stage p1: a same-cycle clear overrides a counted mismatch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (bus.clr_err) begin
      err_cnt <= '0;
    end else if (mis_p0 && state == LOCKED) begin
      err_cnt <= sat_inc(err_cnt);
    end
  end

  assign bus.err_count = err_cnt;
`else
  logic unused_clr_err;
  assign unused_clr_err = bus.clr_err;
  assign bus.err_count  = '0;
`endif

  assign bus.locked    = locked_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.hist_out  = hist;

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Directed bench for lfsr_seq_checker: a behavioural reference pushes expected outputs
// into a scoreboard each cycle; the DUT outputs are popped and compared after the edge.
module tb_lfsr_seq_checker;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lfsr_seq_checker_if #(.WIDTH(5), .ERR_W(8)) bif ();

  lfsr_seq_checker dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

`ifdef LFSR_CHK_ERRCNT_EN
  localparam int EC3 = 3;
  localparam int EC2 = 2;
`else
  localparam int EC3 = 0;
  localparam int EC2 = 0;
`endif

  typedef struct packed {
    logic       lk;
    logic       ep;
    logic [7:0] ec;
    logic [4:0] h;
  } exp_t;

  exp_t sb[$];

  int n_pass  = 0;
  int n_total = 0;

  // reference model state
  int         m_state;  // 0 acquire, 1 check, 2 locked
  int         m_fill;
  int         m_match;
  int         m_bad;
  int         m_err;
  logic [4:0] m_hist;
  logic       m_pulse;

  logic [4:0] gh;
  bit         gap_en;
  int         pulse_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_state = 0; m_fill = 0; m_match = 0; m_bad = 0; m_err = 0;
    m_hist = 5'b0; m_pulse = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic d, input logic clr);
    logic       pred;
    logic       mis;
    logic [4:0] nh;
    bit         counted;
    m_pulse = 1'b0;
    counted = 0;
    if (v) begin
      pred = ^(m_hist & 5'b10100);
      mis  = (d != pred);
      nh   = {m_hist[3:0], d};
      if (m_state == 0) begin
        if (m_fill < 5) m_fill++;
        if (m_fill == 5 && nh != 5'b0) begin m_state = 1; m_match = 0; end
      end else if (m_state == 1) begin
        if (nh == 5'b0) begin m_state = 0; m_fill = 0; end
        else if (mis) m_match = 0;
        else begin
          m_match++;
          if (m_match == 8) begin m_state = 2; m_match = 0; m_bad = 0; end
        end
      end else begin
        if (mis) begin
          m_pulse = 1'b1; counted = 1; m_match = 0; m_bad++;
          if (m_bad == 4) begin m_state = 0; m_fill = 0; m_bad = 0; end
        end else begin
          m_match++;
          if (m_match == 8) begin m_match = 0; m_bad = 0; end
        end
      end
      m_hist = nh;
    end
`ifdef LFSR_CHK_ERRCNT_EN
    if (clr) m_err = 0;
    else if (counted && m_err < 255) m_err++;
`endif
  endtask

  task automatic cycle(input logic v, input logic d, input logic clr);
    exp_t e;
    bif.din_valid = v;
    bif.din       = d;
    bif.clr_err   = clr;
    model_step(v, d, clr);
    e.lk = (m_state == 2);
    e.ep = m_pulse;
    e.ec = 8'(m_err);
    e.h  = m_hist;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("locked",    32'(bif.locked),    32'(e.lk));
    chk("err_pulse", 32'(bif.err_pulse), 32'(e.ep));
    chk("err_count", 32'(bif.err_count), 32'(e.ec));
    chk("hist_out",  32'(bif.hist_out),  32'(e.h));
    if (bif.err_pulse === 1'b1) pulse_cnt++;
    bif.din_valid = 1'b0;
    bif.clr_err   = 1'b0;
  endtask

  task automatic send_bit(input logic d, input logic clr);
    if (gap_en && $urandom_range(0, 2) == 0)
      repeat ($urandom_range(1, 3)) cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    cycle(1'b1, d, clr);
  endtask

  task automatic gen_bit(output logic b);
    b  = ^(gh & 5'b10100);
    gh = {gh[3:0], b};
  endtask

  task automatic send_clean(input int n);
    logic b;
    for (int i = 0; i < n; i++) begin
      gen_bit(b);
      send_bit(b, 1'b0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bif.din_valid = 1'b0; bif.din = 1'b0; bif.clr_err = 1'b0;
    model_reset();
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic       b;
    logic [9:0] mask;
    bit         dropped;
    bit         got;

    gap_en = 0;
    pulse_cnt = 0;
    do_reset();
    chk("rst_locked",    32'(bif.locked),    0);
    chk("rst_err_pulse", 32'(bif.err_pulse), 0);
    chk("rst_err_count", 32'(bif.err_count), 0);
    chk("rst_hist",      32'(bif.hist_out),  0);

    // clean stream from seed 00001
    gh = 5'b00001;
    for (int i = 1; i <= 40; i++) begin
      gen_bit(b);
      send_bit(b, 1'b0);
      if (i == 12) chk("lock_before13", 32'(bif.locked), 0);
      if (i == 13) chk("lock_at13",     32'(bif.locked), 1);
    end
    chk("clean_no_pulse",  pulse_cnt, 0);
    chk("clean_err_count", 32'(bif.err_count), 0);

    // single bit flip while locked
    pulse_cnt = 0;
    mask = '0;
    for (int i = 0; i < 10; i++) begin
      gen_bit(b);
      send_bit(b ^ (i == 0), 1'b0);
      if (bif.err_pulse === 1'b1) mask[i] = 1'b1;
    end
    chk("flip_pulse_pos",   32'(mask), 32'(10'b0000101001));
    chk("flip_pulse_cnt",   pulse_cnt, 3);
    chk("flip_err_count",   32'(bif.err_count), EC3);
    chk("flip_still_lock",  32'(bif.locked), 1);
    send_clean(8);

    // clear coinciding with a counted mismatch, valid gaps from here on
    gap_en = 1;
    chk("pre_clr_count", 32'(bif.err_count), EC3);
    gen_bit(b);
    send_bit(~b, 1'b1);
    chk("clr_err_count", 32'(bif.err_count), 0);
    chk("clr_err_pulse", 32'(bif.err_pulse), 1);
    send_clean(14);
    chk("post_clr_count", 32'(bif.err_count), EC2);
    chk("post_clr_lock",  32'(bif.locked), 1);

    // all-ones stream: loss of lock after the 4th counted mismatch
    pulse_cnt = 0;
    dropped = 0;
    for (int i = 0; i < 40; i++) begin
      send_bit(1'b1, 1'b0);
      if (!dropped && bif.locked === 1'b0) begin
        dropped = 1;
        chk("loss_after_4", pulse_cnt, 4);
      end
    end
    chk("loss_seen", 32'(dropped), 1);
    chk("no_relock", 32'(bif.locked), 0);

    // zero stream stays in acquire; a clean stream then locks within 13 bits
    do_reset();
    for (int i = 0; i < 20; i++) send_bit(1'b0, 1'b0);
    chk("zeros_unlocked", 32'(bif.locked), 0);
    chk("zeros_hist",     32'(bif.hist_out), 0);
    gh = 5'b00001;
    got = 0;
    for (int i = 0; i < 13; i++) begin
      gen_bit(b);
      send_bit(b, 1'b0);
      if (bif.locked === 1'b1) got = 1;
    end
    chk("relock_within13", 32'(got), 1);

    // asynchronous reset mid-stream while locked
    send_clean(10);
    chk("pre_async_lock", 32'(bif.locked), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_locked",    32'(bif.locked),    0);
    chk("async_err_pulse", 32'(bif.err_pulse), 0);
    chk("async_err_count", 32'(bif.err_count), 0);
    chk("async_hist",      32'(bif.hist_out),  0);
    model_reset();
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    gh = 5'b00001;
    send_clean(20);
    chk("reacq_lock", 32'(bif.locked), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
